reg_bank_responder: RTL
=======================

# reg_bank_responder

Clocked responder side of the register-bank handshake used by the decode stage. It serves toggle-triggered operand reads (address in, data plus ready out) from a 16 x 32 ARM register array, and accepts toggle-triggered writes from the writeback path. It sits between decode (read requester) and the ALU/writeback stage (write requester). It is the synchronous replacement for the behavioural register bank model.

## Interface
- READ_LATENCY, 1, cycles from request capture to `readyOut` rising; legal range 1..4
- RESET_VALUE, 32'h0000_0000, value loaded into every register on reset
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- addrIn  in  32  read address; only [3:0] used, [31:4] ignored
- triggerIn  in  1  read request; each toggle (either edge) is one request
- dataOut  out  32  read data; valid while `readyOut`=1 after a request completes
- readyOut  out  1  1 = idle and `dataOut` valid; 0 = read in progress
- wrAddrIn  in  4  write address
- wrDataIn  in  32  write data
- wrTriggerIn  in  1  write request; each toggle is one write
- wrReadyOut  out  1  1 = write port idle; 0 for the cycle a write commits
- errOut  out  1  sticky protocol-violation flag

## Operation
- Toggle detection: registered copies `trigQ`/`wrTrigQ`; a request is detected when the input differs from its copy, and the copy updates the same cycle.
- Read FSM states:
  - IDLE: on detect, capture addrIn[3:0], sample array[addr] into the data holding register, load count = READ_LATENCY, go to BUSY, `readyOut`<=0.
  - BUSY: decrement count; at count==1 drive `dataOut` from the holding register, `readyOut`<=1, go to IDLE.
- Request while BUSY: held as one pending request (address captured at detect); it starts on the cycle after `readyOut` rises. A further toggle while one is already pending is dropped and sets `errOut`.
- Write: on wrTrigger detect, array[wrAddrIn] <= wrDataIn that cycle. `wrReadyOut` is 0 for exactly the next cycle, then 1. Writes are never blocked by reads.
- Simultaneous read capture and write to the same address in one cycle: the read samples the old value unless the bypass is enabled (see Configuration).
- Read and write to different addresses in the same cycle are independent.
- r15 has no special treatment; PC handling belongs elsewhere.

## Timing
- Reset values:
  - all registers = RESET_VALUE
  - dataOut = 0, readyOut = 1, wrReadyOut = 1, errOut = 0
  - FSM = IDLE, pending cleared
  - trigQ <= triggerIn and wrTrigQ <= wrTriggerIn, so no spurious request is detected on release
- Reset mid-read aborts the read: the next cycle shows readyOut=1 and dataOut=0.
- Read latency: toggle at edge N is detected at edge N+1, where readyOut falls. readyOut rises at edge N+1+READ_LATENCY.
- Requester rule: after toggling, wait for readyOut low and then high; dataOut is stable from that rise until the next detected request.
- Back-to-back reads: readyOut is high for at least one cycle between requests.
- A pending request starts on the cycle after that rise.
- Write latency: toggle detected at edge N+1, array updated at the same edge. wrReadyOut is low during cycle N+1 and high again at N+2.

## Configuration
- `RB_WRITE_BYPASS_EN` defined: the read holding register tracks writes. Any write to the captured read address between capture and readyOut rising (including the capture cycle) replaces the held data, so dataOut returns the newest value.
- `RB_WRITE_BYPASS_EN` undefined: dataOut is the array value sampled at the capture edge, and concurrent writes are not visible.

## Test plan
- Reset then idle: readyOut=1, wrReadyOut=1, dataOut=0, errOut=0. Holding triggers at 1 through reset causes no request.
- Write r3=32'hDEAD_BEEF, then a read with addrIn=32'hFFFF_FFF3: readyOut low for READ_LATENCY cycles, then dataOut=32'hDEAD_BEEF.
- Read r5 (holding 32'h1) and write r5=32'h2 in the same cycle: dataOut=32'h1 without the macro, 32'h2 with `RB_WRITE_BYPASS_EN`.
- Three read toggles within one BUSY period (READ_LATENCY=4): first and second are served in order, third is dropped, errOut=1 and stays 1.
- Assert reset during BUSY: next cycle readyOut=1, dataOut=0, and the pending request is cleared.
- Sweep READ_LATENCY over 1..4: readyOut rise lands exactly at detect+READ_LATENCY.

Source files
------------

// File: rtl/reg_bank_responder.sv
// reg_bank_responder: 16 x 32 register bank with a toggle-triggered read
// port (fixed READ_LATENCY, one pending request) and a toggle-triggered
// write port.
// Optional feature macro: RB_WRITE_BYPASS_EN -- when defined, writes to the
// captured read address update the read holding register until completion.
module reg_bank_responder #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] RESET_VALUE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addrIn,
    input  logic        triggerIn,
    output logic [31:0] dataOut,
    output logic        readyOut,
    input  logic [3:0]  wrAddrIn,
    input  logic [31:0] wrDataIn,
    input  logic        wrTriggerIn,
    output logic        wrReadyOut,
    output logic        errOut
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [31:0] regs [16];

    logic        trig_q;
    logic        wr_trig_q;
    logic        wr_ready_q;
    logic        rd_detect;
    logic        wr_detect;

    state_t      state_q,     state_d;
    logic [2:0]  count_q,     count_d;
    logic [3:0]  rd_addr_q,   rd_addr_d;
    logic [31:0] hold_q,      hold_d;
    logic        pend_q,      pend_d;
    logic [3:0]  pend_addr_q, pend_addr_d;
    logic [31:0] data_q,      data_d;
    logic        ready_q,     ready_d;
    logic        err_q,       err_d;

    logic [3:0]  start_addr;
    logic [31:0] start_data;

    assign rd_detect  = triggerIn ^ trig_q;
    assign wr_detect  = wrTriggerIn ^ wr_trig_q;

    // A queued request always starts ahead of a fresh one arriving the same cycle.
    assign start_addr = pend_q ? pend_addr_q : addrIn[3:0];

`ifdef RB_WRITE_BYPASS_EN
    assign start_data = (wr_detect && (wrAddrIn == start_addr)) ? wrDataIn : regs[start_addr];
`else
    assign start_data = regs[start_addr];
`endif

    assign dataOut    = data_q;
    assign readyOut   = ready_q;
    assign wrReadyOut = wr_ready_q;
    assign errOut     = err_q;

    // Toggle-detect copies and write-port ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q     <= triggerIn;
            wr_trig_q  <= wrTriggerIn;
            wr_ready_q <= 1'b1;
        end else begin
            trig_q     <= triggerIn;
            wr_trig_q  <= wrTriggerIn;
            wr_ready_q <= ~wr_detect;
        end
    end

    // Register array: reset fill and write commit on a detected write toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: RESET_VALUE};
        end else if (wr_detect) begin
            regs[wrAddrIn] <= wrDataIn;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_addr_q   <= '0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            data_q      <= '0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_addr_q   <= rd_addr_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    // Read FSM next-state, pending-request and output logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_addr_d   = rd_addr_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        data_d      = data_q;
        ready_d     = ready_q;
        err_d       = err_q;

`ifdef RB_WRITE_BYPASS_EN
        if (wr_detect && (wrAddrIn == rd_addr_q)) begin
            hold_d = wrDataIn;
        end
`endif

        case (state_q)
            IDLE: begin
                if (pend_q || rd_detect) begin
                    state_d   = BUSY;
                    count_d   = 3'(READ_LATENCY);
                    rd_addr_d = start_addr;
                    hold_d    = start_data;
                    ready_d   = 1'b0;
                    // Starting a queued request frees the slot for a toggle seen now.
                    if (pend_q) begin
                        pend_d      = rd_detect;
                        pend_addr_d = addrIn[3:0];
                    end
                end
            end
            BUSY: begin
                count_d = count_q - 3'd1;
                if (count_q == 3'd1) begin
                    state_d = IDLE;
                    data_d  = hold_d;
                    ready_d = 1'b1;
                end
                if (rd_detect) begin
                    if (pend_q) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d      = 1'b1;
                        pend_addr_d = addrIn[3:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
